// File: rtl/cnn_mac_pkg.sv
// cnn_mac_pkg: default widths, pipeline-depth limits and saturation bounds for the MAC pipe
package cnn_mac_pkg;
  localparam int DIN0_W_DEF = 9;
  localparam int DIN1_W_DEF = 14;
  localparam int NUM_STAGE_DEF = 2;
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;
  localparam int ACC_LEN_DEF = 9;
  localparam int ACC_W_DEF = 32;
  localparam int DOUT_W_DEF = 16;
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// cnn_mac_mul_pipe: signed multiplier with NUM_STAGE enabled registers, shaped for DSP inference
module cnn_mac_mul_pipe #(
  parameter int A_W = 9,
  parameter int B_W = 14,
  parameter int P_W = 32,
  parameter int NUM_STAGE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [P_W-1:0] p,
  output logic                  p_valid
);
  logic signed [A_W+B_W-1:0] full;
  logic signed [P_W-1:0] pr [NUM_STAGE];
  logic [NUM_STAGE-1:0] vr;
  assign full = a * b;
  assign p = pr[NUM_STAGE-1];
  assign p_valid = vr[NUM_STAGE-1];
  for (genvar i = 0; i < NUM_STAGE; i++) begin : g
    if (i == 0) begin : h
      // first stage captures the sign-extended product of the accepted pair
      always_ff @(posedge clk) begin
        if (rst) vr[0] <= 1'b0;
        else if (en) vr[0] <= in_valid;
        if (en) pr[0] <= P_W'(full);
      end
    end else begin : h
      // later stages shift product and valid together, holding while stalled
      always_ff @(posedge clk) begin
        if (rst) vr[i] <= 1'b0;
        else if (en) vr[i] <= vr[i-1];
        if (en) pr[i] <= pr[i-1];
      end
    end
  end
endmodule

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed MAC summing ACC_LEN products; CNN_MAC_SAT_EN selects saturating output
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DIN0_W_DEF,
  parameter int DIN1_WIDTH = DIN1_W_DEF,
  parameter int NUM_STAGE = NUM_STAGE_DEF,
  parameter int ACC_LEN = ACC_LEN_DEF,
  parameter int ACC_WIDTH = ACC_W_DEF,
  parameter int DOUT_WIDTH = DOUT_W_DEF
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout
);
  localparam int CW = ACC_LEN > 1 ? $clog2(ACC_LEN) : 1;
  logic stall, p_valid, last;
  logic signed [ACC_WIDTH-1:0] p, acc, sum;
  logic signed [DOUT_WIDTH-1:0] red;
  logic [CW-1:0] cnt;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  cnn_mac_mul_pipe #(
    .A_W(DIN0_WIDTH), .B_W(DIN1_WIDTH), .P_W(ACC_WIDTH), .NUM_STAGE(NUM_STAGE)
  ) u_mul (
    .clk(ap_clk), .rst(ap_rst), .en(~stall), .in_valid(in_valid),
    .a(din0), .b(din1), .p(p), .p_valid(p_valid)
  );
  // running sum restarts at cnt 0; final sum is reduced to the output width
  always_comb begin
    last = cnt == CW'(ACC_LEN - 1);
    sum = cnt == '0 ? p : acc + p;
`ifdef CNN_MAC_SAT_EN
    red = longint'(sum) > sat_max(DOUT_WIDTH) ? DOUT_WIDTH'(sat_max(DOUT_WIDTH)) :
          longint'(sum) < sat_min(DOUT_WIDTH) ? DOUT_WIDTH'(sat_min(DOUT_WIDTH)) :
          sum[DOUT_WIDTH-1:0];
`else
    red = sum[DOUT_WIDTH-1:0];
`endif
  end
  // accumulate valid products and publish each finished sum, freezing under backpressure
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      dout <= '0;
    end else if (!stall) begin
      out_valid <= p_valid & last;
      if (p_valid) begin
        acc <= sum;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) dout <= red;
      end
    end
  end
endmodule
